debounce_ce_gen: RTL and testbench

- Upstream conditioning stage for the clock-enabled flip-flops in the datapath.
- Takes a raw asynchronous input (button or switch) and produces a synchronised, debounced level (dout) that serves as the flop's D.
- Also produces a periodic one-cycle strobe (tick) that serves as the flop's clock enable.
- Generates one-cycle rise and fall pulses on debounced edges.

---
 rtl/debounce_ce_gen.sv | 128 ++++++++++++
 tb/tb_debounce_ce_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_ce_gen.sv
// Input conditioner: 2-flop synchroniser, tick prescaler and tick-sampled debounce FSM.
// Produces a clean level (dout), a periodic clock-enable strobe (tick) and edge pulses.
module debounce_ce_gen #(
    parameter int TICK_DIV   = 1000,
    parameter int STABLE_CNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din,
    output logic tick,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CNT - 1);

    typedef enum logic [1:0] {S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK} state_t;

    logic [1:0]    sync_q;
    logic          din_s;
    logic [CW-1:0] cnt;
    logic          wrap;
    logic [SW-1:0] stab, stab_nxt;
    state_t        state, state_nxt;
    logic          dout_nxt;

    assign din_s = sync_q[1];
    assign wrap  = en && (cnt == CNT_MAX);

    // Synchroniser runs regardless of en so din_s is fresh when en returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            if (en) cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOW;
            stab  <= '0;
        end else begin
            state <= state_nxt;
            stab  <= stab_nxt;
        end
    end

    // The FSM only moves on the same edge that raises tick.
    always_comb begin
        state_nxt = state;
        stab_nxt  = stab;
        if (wrap) begin
            case (state)
                S_LOW: if (din_s) begin
                    if (STABLE_CNT == 1) state_nxt = S_HIGH;
                    else begin
                        state_nxt = S_RISE_CHK;
                        stab_nxt  = SW'(1);
                    end
                end
                S_RISE_CHK: begin
                    if (!din_s) begin
                        state_nxt = S_LOW;
                        stab_nxt  = '0;
                    end else if (stab == STAB_LAST) begin
                        state_nxt = S_HIGH;
                        stab_nxt  = '0;
                    end else begin
                        stab_nxt = stab + SW'(1);
                    end
                end
                S_HIGH: if (!din_s) begin
                    if (STABLE_CNT == 1) state_nxt = S_LOW;
                    else begin
                        state_nxt = S_FALL_CHK;
                        stab_nxt  = SW'(1);
                    end
                end
                S_FALL_CHK: begin
                    if (din_s) begin
                        state_nxt = S_HIGH;
                        stab_nxt  = '0;
                    end else if (stab == STAB_LAST) begin
                        state_nxt = S_LOW;
                        stab_nxt  = '0;
                    end else begin
                        stab_nxt = stab + SW'(1);
                    end
                end
                default: begin
                    state_nxt = S_LOW;
                    stab_nxt  = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the pulses line up with the dout edge.
    always_comb begin
        dout_nxt = (state_nxt == S_HIGH) || (state_nxt == S_FALL_CHK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            dout <= dout_nxt;
            rise <= dout_nxt && !dout;
            fall <= !dout_nxt && dout;
        end
    end

endmodule

// File: tb/tb_debounce_ce_gen.sv
// Bench for debounce_ce_gen: two instances (TICK_DIV=4/STABLE_CNT=3 and 1/1) checked
// every cycle against a tick/run-length model, plus hand-computed edge-numbered expectations.
module tb_debounce_ce_gen;

    logic clk = 1'b0;
    logic rst_n, en, din0, din1;
    logic tick0, dout0, rise0, fall0;
    logic tick1, dout1, rise1, fall1;

    int n_chk  = 0;
    int n_fail = 0;
    int ecnt;
    logic [2:0] d1h = '0;

    always #5 clk = ~clk;

    debounce_ce_gen #(.TICK_DIV(4), .STABLE_CNT(3)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din0),
        .tick(tick0), .dout(dout0), .rise(rise0), .fall(fall0));

    debounce_ce_gen #(.TICK_DIV(1), .STABLE_CNT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din1),
        .tick(tick1), .dout(dout1), .rise(rise1), .fall(fall1));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t edge=%0d: got %0d expected %0d", name, $time, ecnt, act, exp);
        end
    endtask

    // Edge counter since reset release; the directed expectations are keyed on it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    always @(posedge clk) d1h <= {d1h[1:0], din1};

    // Model: din delayed two edges; every TICK_DIV-th enabled edge is a tick; a level
    // flips once STABLE_CNT consecutive ticks have seen the opposite level.
    bit m_s   [2][2];
    int m_eno [2];
    bit m_lvl [2];
    int m_run [2];
    bit m_tick[2];
    bit m_rise[2];
    bit m_fall[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_s[i][0] = 0; m_s[i][1] = 0; m_eno[i] = 0; m_lvl[i] = 0;
                m_run[i] = 0; m_tick[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin : mstep
                bit ds;
                int td, sc;
                td = (i == 0) ? 4 : 1;
                sc = (i == 0) ? 3 : 1;
                ds = m_s[i][1];
                m_s[i][1] = m_s[i][0];
                m_s[i][0] = (i == 0) ? din0 : din1;
                m_tick[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
                if (en) begin
                    m_eno[i]++;
                    if (m_eno[i] % td == 0) begin
                        m_tick[i] = 1;
                        if (ds != m_lvl[i]) begin
                            m_run[i]++;
                            if (m_run[i] == sc) begin
                                m_lvl[i]  = ds;
                                m_run[i]  = 0;
                                m_rise[i] = ds;
                                m_fall[i] = !ds;
                            end
                        end else begin
                            m_run[i] = 0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_tick0", tick0, m_tick[0]);
        chk("m_dout0", dout0, m_lvl[0]);
        chk("m_rise0", rise0, m_rise[0]);
        chk("m_fall0", fall0, m_fall[0]);
        chk("m_tick1", tick1, m_tick[1]);
        chk("m_dout1", dout1, m_lvl[1]);
        chk("m_rise1", rise1, m_rise[1]);
        chk("m_fall1", fall1, m_fall[1]);
        chk("excl0", int'(rise0 && fall0), 0);
        chk("excl1", int'(rise1 && fall1), 0);
    end

    task automatic go_to(input int n);
        int g = 0;
        while (ecnt < n && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (ecnt != n) chk("go_to", ecnt, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; din0 = 1'b0; din1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tick", tick0, 0);
        chk("rst_dout", dout0, 0);
        rst_n = 1'b1;

        // Idle din=0: ticks on edges 4, 8, 12 only.
        for (int e = 1; e <= 12; e++) begin
            go_to(e);
            chk("t1_tick", tick0, (e % 4 == 0) ? 1 : 0);
            chk("t1_dout", dout0, 0);
        end

        // 5-cycle pulse: tick 16 starts a check, tick 20 sees 0 and aborts.
        din0 = 1'b1;
        go_to(17);
        din0 = 1'b0;
        for (int e = 18; e <= 28; e++) begin
            go_to(e);
            chk("t3_dout", dout0, 0);
            chk("t3_rise", rise0, 0);
        end

        // Clean rise: din_s=1 after edge 30, ticks 32/36/40.
        din0 = 1'b1;
        go_to(39);
        chk("t2_dout_pre", dout0, 0);
        go_to(40);
        chk("t2_dout", dout0, 1);
        chk("t2_rise", rise0, 1);
        chk("t2_fall", fall0, 0);
        go_to(41);
        chk("t2_rise_end", rise0, 0);

        // Fall check starts at tick 44, then en low for edges 45..64.
        din0 = 1'b0;
        go_to(44);
        chk("t4_tick44", tick0, 1);
        en = 1'b0;
        for (int e = 45; e <= 64; e++) begin
            go_to(e);
            chk("t4_frz_tick", tick0, 0);
            chk("t4_frz_dout", dout0, 1);
        end
        en = 1'b1;
        go_to(67);
        chk("t4_tick67", tick0, 0);
        go_to(68);
        chk("t4_tick68", tick0, 1);
        chk("t4_dout68", dout0, 1);
        go_to(71);
        chk("t4_dout71", dout0, 1);
        go_to(72);
        chk("t4_dout72", dout0, 0);
        chk("t4_fall72", fall0, 1);
        go_to(73);
        chk("t4_fall_end", fall0, 0);

        // Rise check starts at tick 76; reset mid-cycle while tick is high.
        din0 = 1'b1;
        go_to(76);
        chk("t5_tick76", tick0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_tick", tick0, 0);
        chk("t5_async_dout", dout0, 0);
        chk("t5_async_rise", rise0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        go_to(3);
        chk("t5_tick3", tick0, 0);
        go_to(4);
        chk("t5_tick4", tick0, 1);
        go_to(11);
        chk("t5_dout11", dout0, 0);
        go_to(12);
        chk("t5_dout12", dout0, 1);
        chk("t5_rise12", rise0, 1);
        go_to(14);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_hi_dout", dout0, 0);
        chk("t5_rst_hi_fall", fall0, 0);
        repeat (2) @(negedge clk);
        din0 = 1'b0;
        rst_n = 1'b1;

        // TICK_DIV=1/STABLE_CNT=1: din1 toggles every 3 cycles, dout1 lags by 3 edges.
        for (int k = 0; k < 36; k++) begin
            if (k % 3 == 0) din1 = ~din1;
            @(negedge clk);
            chk("t6_tick", tick1, 1);
            chk("t6_dout", dout1, d1h[2]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
